sdram_arbit: RTL and testbench

- Central arbiter and command multiplexer for the 166 MHz SDRAM controller.
- Holds the bus for the init sequencer until init_end, then grants the SDRAM to the auto-refresh, write and read sub-modules.
- Priority: refresh first; write and read alternate when both are pending.
- Drives the single SDRAM command/address/data interface, and enables each sub-module with a registered enable. A watchdog recovers from a sub-module that never signals completion.

---
 rtl/sdram_arbit.sv | 155 +++++++++++++++
 tb/tb_sdram_arbit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sdram_arbit.sv
// sdram_arbit: arbiter and command multiplexer for the SDRAM controller.
// The init sequencer owns the bus until init_end. After that, grants go to
// refresh, write and read. Refresh has priority. Write and read alternate
// when both are pending. A watchdog ends any grant whose *_end never arrives.
module sdram_arbit #(
    parameter int               DATA_W      = 16,
    parameter int               CNT_W       = 11,
    parameter logic [CNT_W-1:0] TIMEOUT_MAX = 11'd2000
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [3:0]        init_cmd,
    input  logic [1:0]        init_ba,
    input  logic [12:0]       init_addr,
    input  logic              init_end,
    input  logic              aref_req,
    input  logic [3:0]        aref_cmd,
    input  logic [1:0]        aref_ba,
    input  logic [12:0]       aref_addr,
    input  logic              aref_end,
    input  logic              wr_req,
    input  logic [3:0]        wr_cmd,
    input  logic [1:0]        wr_ba,
    input  logic [12:0]       wr_addr,
    input  logic              wr_sdram_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_end,
    input  logic              rd_req,
    input  logic [3:0]        rd_cmd,
    input  logic [1:0]        rd_ba,
    input  logic [12:0]       rd_addr,
    input  logic              rd_end,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [1:0]        sdram_ba,
    output logic [12:0]       sdram_addr,
    output logic [DATA_W-1:0] sdram_dq_out,
    output logic              sdram_dq_oe,
    output logic              arb_err
);

    typedef enum logic [2:0] {INIT, ARBIT, AREF, WRITE, READ} state_t;

    localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] WD_LAST = TIMEOUT_MAX - ONE;
    localparam logic [3:0]       NOP     = 4'b0111;

    state_t           state;
    logic             last_wr;
    logic [CNT_W-1:0] wdog;
    logic             grant_end;
    logic             wd_hit;

    // The completion pulse counts only when it belongs to the current grant.
    always_comb begin
        grant_end = (state == AREF  && aref_end) ||
                    (state == WRITE && wr_end)   ||
                    (state == READ  && rd_end);
        wd_hit    = (wdog == WD_LAST);
    end

    // Grant FSM, enables, watchdog and the sticky error flag.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= INIT;
            aref_en   <= 1'b0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            sdram_cke <= 1'b0;
            arb_err   <= 1'b0;
            last_wr   <= 1'b0;
            wdog      <= '0;
        end else begin
            sdram_cke <= 1'b1;
            case (state)
                INIT: begin
                    wdog <= '0;
                    if (init_end) state <= ARBIT;
                end
                ARBIT: begin
                    wdog <= '0;
                    if (aref_req) begin
                        state   <= AREF;
                        aref_en <= 1'b1;
                    end else if (wr_req && !(rd_req && last_wr)) begin
                        state   <= WRITE;
                        wr_en   <= 1'b1;
                        last_wr <= 1'b1;
                    end else if (rd_req) begin
                        state   <= READ;
                        rd_en   <= 1'b1;
                        last_wr <= 1'b0;
                    end
                end
                AREF, WRITE, READ: begin
                    if (grant_end || wd_hit) begin
                        state   <= ARBIT;
                        aref_en <= 1'b0;
                        wr_en   <= 1'b0;
                        rd_en   <= 1'b0;
                        wdog    <= '0;
                        // A completion in the timeout cycle is a normal end.
                        if (!grant_end) arb_err <= 1'b1;
                    end else begin
                        wdog <= wdog + ONE;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    // The command bus follows whichever agent owns the state. ARBIT drives a NOP.
    always_comb begin
        {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = NOP;
        sdram_ba   = 2'b11;
        sdram_addr = 13'h1fff;
        case (state)
            INIT: begin
                {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
            AREF: begin
                {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = aref_cmd;
                sdram_ba   = aref_ba;
                sdram_addr = aref_addr;
            end
            WRITE: begin
                {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = wr_cmd;
                sdram_ba   = wr_ba;
                sdram_addr = wr_addr;
            end
            READ: begin
                {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_addr;
            end
            default: ;
        endcase
    end

    // DQ is driven only during the data phase of a write grant.
    always_comb begin
        sdram_dq_out = wr_data;
        sdram_dq_oe  = (state == WRITE) && wr_sdram_en;
    end

endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: random and directed stimulus. Each cycle the outputs are
// compared with a bus-ownership model of the arbiter rules.
module tb_sdram_arbit;

    localparam int DW  = 16;
    localparam int TMO = 2000;

    localparam int O_INIT = 0, O_IDLE = 1, O_REF = 2, O_WR = 3, O_RD = 4;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic [3:0]    init_cmd, aref_cmd, wr_cmd, rd_cmd;
    logic [1:0]    init_ba, aref_ba, wr_ba, rd_ba;
    logic [12:0]   init_addr, aref_addr, wr_addr, rd_addr;
    logic          init_end, aref_req, aref_end, wr_req, wr_sdram_en, wr_end;
    logic          rd_req, rd_end;
    logic [DW-1:0] wr_data;
    logic          aref_en, wr_en, rd_en, sdram_cke;
    logic          sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]    sdram_ba;
    logic [12:0]   sdram_addr;
    logic [DW-1:0] sdram_dq_out;
    logic          sdram_dq_oe, arb_err;

    int checks = 0;
    int failures = 0;

    // Reference model: who owns the bus and for how long.
    int   m_own;
    int   m_age;
    logic m_last_wr, m_err, m_cke;

    always #3 sys_clk = ~sys_clk;

    sdram_arbit #(.DATA_W(DW), .CNT_W(11), .TIMEOUT_MAX(11'd2000)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr), .init_end(init_end),
        .aref_req(aref_req), .aref_cmd(aref_cmd), .aref_ba(aref_ba), .aref_addr(aref_addr),
        .aref_end(aref_end),
        .wr_req(wr_req), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
        .wr_sdram_en(wr_sdram_en), .wr_data(wr_data), .wr_end(wr_end),
        .rd_req(rd_req), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr), .rd_end(rd_end),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(sdram_cke),
        .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
        .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
        .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe), .arb_err(arb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [18:0] exp_bus();
        case (m_own)
            O_INIT:  return {init_cmd, init_ba, init_addr};
            O_REF:   return {aref_cmd, aref_ba, aref_addr};
            O_WR:    return {wr_cmd, wr_ba, wr_addr};
            O_RD:    return {rd_cmd, rd_ba, rd_addr};
            default: return {4'b0111, 2'b11, 13'h1fff};
        endcase
    endfunction

    // One clock: advance the model on the edge and compare outputs 1 ns later.
    task automatic step();
        bit done;
        @(posedge sys_clk);
        if (sys_rst) begin
            m_own = O_INIT; m_age = 0; m_last_wr = 1'b0; m_err = 1'b0; m_cke = 1'b0;
        end else begin
            m_cke = 1'b1;
            if (m_own == O_INIT) begin
                if (init_end) m_own = O_IDLE;
            end else if (m_own == O_IDLE) begin
                m_age = 0;
                if (aref_req) m_own = O_REF;
                else if (wr_req && rd_req) begin
                    m_own = m_last_wr ? O_RD : O_WR;
                    m_last_wr = !m_last_wr;
                end else if (wr_req) begin
                    m_own = O_WR; m_last_wr = 1'b1;
                end else if (rd_req) begin
                    m_own = O_RD; m_last_wr = 1'b0;
                end
            end else begin
                m_age++;
                done = (m_own == O_REF && aref_end) || (m_own == O_WR && wr_end) ||
                       (m_own == O_RD && rd_end);
                if (done) m_own = O_IDLE;
                else if (m_age >= TMO) begin
                    m_own = O_IDLE; m_err = 1'b1;
                end
            end
        end
        #1;
        chk("enables", {29'd0, aref_en, wr_en, rd_en},
            {29'd0, m_own == O_REF, m_own == O_WR, m_own == O_RD});
        chk("cmd_bus", {13'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr},
            {13'd0, exp_bus()});
        chk("dq", {15'd0, sdram_dq_oe, sdram_dq_out},
            {15'd0, (m_own == O_WR) && wr_sdram_en, wr_data});
        chk("arb_err", {31'd0, arb_err}, {31'd0, m_err});
        chk("cke", {31'd0, sdram_cke}, {31'd0, m_cke});
    endtask

    // mode 0: random requests, 1: write+read held, 2: read held with no ends,
    // 3: write only with data phase A5A5.
    task automatic drive(input int mode);
        init_cmd = 4'($urandom); init_ba = 2'($urandom); init_addr = 13'($urandom);
        aref_cmd = 4'($urandom); aref_ba = 2'($urandom); aref_addr = 13'($urandom);
        wr_cmd   = 4'($urandom); wr_ba   = 2'($urandom); wr_addr   = 13'($urandom);
        rd_cmd   = 4'($urandom); rd_ba   = 2'($urandom); rd_addr   = 13'($urandom);
        wr_data  = 16'($urandom); wr_sdram_en = 1'($urandom);
        aref_end = (m_own == O_REF) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
        wr_end   = (m_own == O_WR)  ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
        rd_end   = (m_own == O_RD)  ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
        case (mode)
            1: begin aref_req = 1'b0; wr_req = 1'b1; rd_req = 1'b1; end
            2: begin aref_req = 1'b0; wr_req = 1'b0; rd_req = 1'b1; rd_end = 1'b0; end
            3: begin
                aref_req = 1'b0; wr_req = 1'b1; rd_req = 1'b0;
                wr_sdram_en = 1'b1; wr_data = 16'hA5A5;
            end
            default: begin
                aref_req = ($urandom_range(0, 4) == 0);
                wr_req   = 1'($urandom);
                rd_req   = 1'($urandom);
            end
        endcase
    endtask

    task automatic run(input int mode, input int n);
        for (int i = 0; i < n; i++) begin
            drive(mode);
            step();
        end
    endtask

    initial begin
        m_own = O_INIT; m_age = 0; m_last_wr = 1'b0; m_err = 1'b0; m_cke = 1'b0;
        aref_req = 0; wr_req = 0; rd_req = 0; aref_end = 0; wr_end = 0; rd_end = 0;
        aref_cmd = 0; aref_ba = 0; aref_addr = 0; wr_cmd = 0; wr_ba = 0; wr_addr = 0;
        rd_cmd = 0; rd_ba = 0; rd_addr = 0; wr_sdram_en = 0; wr_data = 0;
        init_cmd = 4'b0010; init_ba = 2'b00; init_addr = 13'h0400; init_end = 1'b0;
        sys_rst = 1'b1;
        repeat (3) step();
        sys_rst = 1'b0;
        // The init sequencer owns the bus while init_end stays low.
        repeat (20) step();
        init_end = 1'b1;
        step();
        // All three requests pending: refresh first, then write.
        aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        step();
        aref_end = 1'b1;
        step();
        aref_end = 1'b0; aref_req = 1'b0;
        repeat (3) step();
        run(1, 200);
        run(3, 40);
        run(0, 3000);
        // Read granted with no rd_end: the watchdog must recover.
        run(2, 2 * TMO + 20);
        run(0, 300);
        sys_rst = 1'b1;
        repeat (2) step();
        sys_rst = 1'b0;
        run(0, 100);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
